// File: rtl/sram_pkg.sv
// Shared definitions for the 1RW+1R behavioural SRAM model:
// width helpers and the scrub controller state type.
package sram_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } sram_state_t;

  function automatic int addr_width(int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int num_wmasks(int word_width, int gran);
    return word_width / gran;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: data, valid and collision flag delayed by
// LATENCY stages; data stages only load on valid so outputs hold.
module sram_rd_pipe #(
  parameter int WIDTH   = 65,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_coll,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_coll
);

  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] c;
  logic [WIDTH-1:0]   d [LATENCY];

  // shift valid/coll every cycle, load data only behind a valid
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      c <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      c[0] <= in_valid & in_coll;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        c[i] <= c[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LATENCY-1];
  assign out_data  = d[LATENCY-1];
  assign out_coll  = c[LATENCY-1];

endmodule

// File: rtl/sram_model_1rw1r.sv
// Behavioural 1RW+1R SRAM with lane write mask, optional spare bit,
// post-reset zero scrub and read-first collision reporting.
module sram_model_1rw1r
  import sram_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int WORD_WIDTH   = 64,
  parameter int MASK_GRAN    = 8,
  parameter int SPARE        = 1,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_WIDTH  = addr_width(DEPTH),
  localparam int NUM_WMASKS  = num_wmasks(WORD_WIDTH, MASK_GRAN),
  localparam int DATA_WIDTH  = WORD_WIDTH + SPARE
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic                  spare_wen0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1,
  output logic                  coll1
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_t           state_q;
  sram_state_t           state_d;
  logic                  scrub_en;
  logic [ADDR_WIDTH-1:0] cnt;

  logic                  acc0;
  logic                  rd0;
  logic                  rd1;
  logic                  in0;
  logic                  in1;
  logic                  wr_ok;
  logic                  coll;
  logic                  coll0_unused;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] merged;

  assign busy  = (state_q == SCRUB);
  assign acc0  = !busy && !rst && !csb0;
  assign rd0   = acc0 && web0;
  assign rd1   = !busy && !rst && !csb1;
  assign in0   = ({1'b0, addr0} < DEPTH_L);
  assign in1   = ({1'b0, addr1} < DEPTH_L);
  assign wr_ok = acc0 && !web0 && in0;
  assign coll  = rd1 && wr_ok && (addr1 == addr0);

  // old-word reads; out-of-range addresses read as zero
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    if (in0) rdata0 = mem[addr0];
    if (in1) rdata1 = mem[addr1];
  end

  // merge enabled lanes and spare bit over the current word
  always_comb begin
    merged = rdata0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i])
        merged[i*MASK_GRAN +: MASK_GRAN] = din0[i*MASK_GRAN +: MASK_GRAN];
    end
    if (SPARE == 1 && spare_wen0)
      merged[DATA_WIDTH-1] = din0[DATA_WIDTH-1];
  end

  // scrub controller state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SCRUB;
    else     state_q <= state_d;
  end

  // scrub controller next state: leave after the last word
  always_comb begin
    state_d  = state_q;
    scrub_en = 1'b0;
    unique case (state_q)
      SCRUB: begin
        scrub_en = 1'b1;
        if (cnt == LAST) state_d = READY;
      end
      READY: state_d = READY;
    endcase
  end

  // scrub word counter
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (scrub_en && cnt != LAST) cnt <= cnt + ADDR_WIDTH'(1);
  end

  // array update: scrub zeroing or port-0 masked write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (scrub_en)   mem[cnt]   <= '0;
      else if (wr_ok) mem[addr0] <= merged;
    end
  end

  sram_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd0),
    .in_data   (rdata0),
    .in_coll   (1'b0),
    .out_valid (rvalid0),
    .out_data  (dout0),
    .out_coll  (coll0_unused)
  );

  sram_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd1),
    .in_data   (rdata1),
    .in_coll   (coll),
    .out_valid (rvalid1),
    .out_data  (dout1),
    .out_coll  (coll1)
  );

endmodule

// File: tb/tb_sram_model_1rw1r.sv
// Directed bench for sram_model_1rw1r: a 16-word latency-1 instance
// and a 12-word latency-2 instance, read results scoreboarded.
module tb_sram_model_1rw1r;

  typedef struct {
    logic [16:0] data;
    logic        coll;
    int          due;
  } exp_t;

  logic clk;
  logic rst;

  logic        a_busy, b_busy;
  logic        a_csb0, a_web0, a_spare_wen0, a_csb1;
  logic [1:0]  a_wmask0;
  logic [3:0]  a_addr0, a_addr1;
  logic [16:0] a_din0, a_dout0, a_dout1;
  logic        a_rvalid0, a_rvalid1, a_coll1;
  logic        b_csb0, b_web0, b_spare_wen0, b_csb1;
  logic [1:0]  b_wmask0;
  logic [3:0]  b_addr0, b_addr1;
  logic [16:0] b_din0, b_dout0, b_dout1;
  logic        b_rvalid0, b_rvalid1, b_coll1;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  logic [16:0] la0, la1, lb0, lb1;
  int cyc;
  int checks;
  int errors;

  sram_model_1rw1r #(
    .DEPTH(16), .WORD_WIDTH(16), .MASK_GRAN(8),
    .SPARE(1), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .busy(a_busy),
    .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0),
    .spare_wen0(a_spare_wen0), .addr0(a_addr0), .din0(a_din0),
    .dout0(a_dout0), .rvalid0(a_rvalid0),
    .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1),
    .rvalid1(a_rvalid1), .coll1(a_coll1)
  );

  sram_model_1rw1r #(
    .DEPTH(12), .WORD_WIDTH(16), .MASK_GRAN(8),
    .SPARE(1), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .rst(rst), .busy(b_busy),
    .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0),
    .spare_wen0(b_spare_wen0), .addr0(b_addr0), .din0(b_din0),
    .dout0(b_dout0), .rvalid0(b_rvalid0),
    .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1),
    .rvalid1(b_rvalid1), .coll1(b_coll1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [16:0] obs, logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_csb0 = 1'b1; a_web0 = 1'b1; a_csb1 = 1'b1;
    b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1;
    a_wmask0 = '0; a_spare_wen0 = 1'b0;
    b_wmask0 = '0; b_spare_wen0 = 1'b0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (qa0.size() > 0 && qa0[0].due == cyc) begin
      e = qa0.pop_front();
      chk("a0_rvalid", 17'(a_rvalid0), 17'd1);
      chk("a0_dout", a_dout0, e.data);
      la0 = e.data;
    end else begin
      chk("a0_idle", 17'(a_rvalid0), 17'd0);
      chk("a0_hold", a_dout0, la0);
    end
    if (qa1.size() > 0 && qa1[0].due == cyc) begin
      e = qa1.pop_front();
      chk("a1_rvalid", 17'(a_rvalid1), 17'd1);
      chk("a1_dout", a_dout1, e.data);
      chk("a1_coll", 17'(a_coll1), 17'(e.coll));
      la1 = e.data;
    end else begin
      chk("a1_idle", 17'(a_rvalid1), 17'd0);
      chk("a1_hold", a_dout1, la1);
      chk("a1_coll_idle", 17'(a_coll1), 17'd0);
    end
    if (qb0.size() > 0 && qb0[0].due == cyc) begin
      e = qb0.pop_front();
      chk("b0_rvalid", 17'(b_rvalid0), 17'd1);
      chk("b0_dout", b_dout0, e.data);
      lb0 = e.data;
    end else begin
      chk("b0_idle", 17'(b_rvalid0), 17'd0);
      chk("b0_hold", b_dout0, lb0);
    end
    if (qb1.size() > 0 && qb1[0].due == cyc) begin
      e = qb1.pop_front();
      chk("b1_rvalid", 17'(b_rvalid1), 17'd1);
      chk("b1_dout", b_dout1, e.data);
      chk("b1_coll", 17'(b_coll1), 17'(e.coll));
      lb1 = e.data;
    end else begin
      chk("b1_idle", 17'(b_rvalid1), 17'd0);
      chk("b1_hold", b_dout1, lb1);
      chk("b1_coll_idle", 17'(b_coll1), 17'd0);
    end
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    la0 = '0; la1 = '0; lb0 = '0; lb1 = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic a_rd0(logic [3:0] ad, logic [16:0] e);
    a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = ad;
    qa0.push_back('{e, 1'b0, cyc + 1});
  endtask

  task automatic a_rd1(logic [3:0] ad, logic [16:0] e, logic c);
    a_csb1 = 1'b0; a_addr1 = ad;
    qa1.push_back('{e, c, cyc + 1});
  endtask

  task automatic a_wr(logic [3:0] ad, logic [16:0] d, logic [1:0] m,
                      logic s);
    a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = ad;
    a_din0 = d; a_wmask0 = m; a_spare_wen0 = s;
  endtask

  task automatic b_rd0(logic [3:0] ad, logic [16:0] e);
    b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = ad;
    qb0.push_back('{e, 1'b0, cyc + 2});
  endtask

  task automatic b_rd1(logic [3:0] ad, logic [16:0] e, logic c);
    b_csb1 = 1'b0; b_addr1 = ad;
    qb1.push_back('{e, c, cyc + 2});
  endtask

  task automatic b_wr(logic [3:0] ad, logic [16:0] d, logic [1:0] m,
                      logic s);
    b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = ad;
    b_din0 = d; b_wmask0 = m; b_spare_wen0 = s;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    a_addr0 = '0; a_addr1 = '0; a_din0 = '0;
    b_addr0 = '0; b_addr1 = '0; b_din0 = '0;
    idle();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      chk("a_busy_scrub", 17'(a_busy), 17'd1);
      if (i < 12) chk("b_busy_scrub", 17'(b_busy), 17'd1);
      tick();
    end
    chk("a_busy_ready", 17'(a_busy), 17'd0);
    chk("b_busy_ready", 17'(b_busy), 17'd0);

    for (int i = 0; i < 16; i++) begin
      a_rd0(4'(i), 17'h0);
      a_rd1(4'(15 - i), 17'h0, 1'b0);
      if (i < 12) begin
        b_rd0(4'(i), 17'h0);
        b_rd1(4'(11 - i), 17'h0, 1'b0);
      end
      tick();
    end
    tick();
    tick();

    a_wr(4'd3, 17'h1ABCD, 2'b01, 1'b0);
    tick();
    a_rd0(4'd3, 17'h000CD);
    a_rd1(4'd3, 17'h000CD, 1'b0);
    tick();

    a_wr(4'd5, 17'h0BEEF, 2'b11, 1'b1);
    a_rd1(4'd5, 17'h0, 1'b1);
    tick();
    a_rd1(4'd5, 17'h0BEEF, 1'b0);
    a_rd0(4'd5, 17'h0BEEF);
    tick();

    a_wr(4'd7, 17'h11234, 2'b10, 1'b1);
    tick();
    a_rd0(4'd7, 17'h11200);
    tick();

    a_wr(4'd3, 17'h0FF00, 2'b10, 1'b1);
    tick();
    a_rd1(4'd3, 17'h0FFCD, 1'b0);
    tick();

    a_wr(4'd5, 17'h1FFFF, 2'b00, 1'b0);
    a_rd1(4'd5, 17'h0BEEF, 1'b1);
    tick();
    a_rd0(4'd5, 17'h0BEEF);
    tick();

    b_wr(4'd11, 17'h05A5A, 2'b11, 1'b0);
    tick();
    b_rd1(4'd11, 17'h05A5A, 1'b0);
    tick();
    b_rd1(4'd13, 17'h0, 1'b0);
    b_wr(4'd13, 17'h1FFFF, 2'b11, 1'b1);
    tick();
    b_rd0(4'd11, 17'h05A5A);
    b_rd1(4'd1, 17'h0, 1'b0);
    tick();
    b_rd0(4'd13, 17'h0);
    tick();
    tick();
    tick();

    a_rd0(4'd5, 17'h0BEEF);
    b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 4'd11;
    tick();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      chk("a_busy_pre", 17'(a_busy), 17'd1);
      tick();
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("a_busy_restart", 17'(a_busy), 17'd1);
      tick();
    end
    chk("a_busy_done", 17'(a_busy), 17'd0);
    chk("b_busy_done", 17'(b_busy), 17'd0);

    a_rd0(4'd3, 17'h0);
    a_rd1(4'd5, 17'h0, 1'b0);
    b_rd0(4'd11, 17'h0);
    tick();
    tick();
    tick();

    chk("queues_drained",
        17'(qa0.size() + qa1.size() + qb0.size() + qb1.size()), 17'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
